cache_replacement_unit: RTL and testbench

CACHE_REPLACEMENT_UNIT -- requirements
Module: cache_replacement_unit

---
 rtl/cache_replacement_unit.sv | 105 ++++++++++
 tb/tb_cache_replacement_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_replacement_unit.sv
// cache_replacement_unit: per-set round-robin or tree pseudo-LRU victim selection with a sweeping flush
module cache_replacement_unit #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int POLICY = 0,
    localparam int SET_W = $clog2(NUM_SETS),
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SET_W-1:0] lookup_set,
    input  logic [NUM_WAYS-1:0] valid_mask,
    output logic [WAY_W-1:0] preferred,
    input  logic             access_en,
    input  logic [SET_W-1:0] access_set,
    input  logic [WAY_W-1:0] access_way,
    input  logic             replace_en,
    input  logic [SET_W-1:0] replace_set,
    input  logic [WAY_W-1:0] replace_way,
    input  logic             flush,
    output logic             busy
);
    if (POLICY != 0 && POLICY != 1) begin : g_bad_policy
        $error("POLICY must be 0 or 1");
    end

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t state, state_nxt;
    logic [SET_W-1:0] idx;
    logic [WAY_W-1:0] rr_ptr [NUM_SETS];
    logic [WAY_W-1:0] rr_nxt [NUM_SETS];
    logic [NUM_WAYS-2:0] plru [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_nxt [NUM_SETS];
    logic [WAY_W-1:0] inv;
    logic upd;

    // Tree nodes are heap-ordered: node n has children 2n+1 (lower half) and 2n+2 (upper half).
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] t, input logic [WAY_W-1:0] w);
        int n;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            t[n] = ~w[WAY_W-1-l];
            n = 2 * n + 1 + int'(w[WAY_W-1-l]);
        end
        return t;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] t);
        logic [WAY_W-1:0] v;
        int n;
        n = 0;
        v = '0;
        for (int l = 0; l < WAY_W; l++) begin
            v[WAY_W-1-l] = t[n];
            n = 2 * n + 1 + int'(t[n]);
        end
        return v;
    endfunction

    always_comb begin
        busy = state == FLUSH;
        state_nxt = state == IDLE ? (flush ? FLUSH : IDLE) : (idx == SET_W'(NUM_SETS - 1) ? IDLE : FLUSH);
        upd = state == IDLE && !flush;
    end

    // Access is folded in before replace so a same-set replace acts on the accessed tree.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            rr_nxt[s] = rr_ptr[s];
            plru_nxt[s] = plru[s];
            if (upd && access_en && access_set == SET_W'(s))
                plru_nxt[s] = plru_touch(plru_nxt[s], access_way);
            if (upd && replace_en && replace_set == SET_W'(s)) begin
                rr_nxt[s] = replace_way + WAY_W'(1);
                plru_nxt[s] = plru_touch(plru_nxt[s], replace_way);
            end
        end
    end

    always_comb begin
        inv = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!valid_mask[i]) inv = WAY_W'(i);
        preferred = busy ? '0 : !(&valid_mask) ? inv : POLICY == 1 ? plru_victim(plru[lookup_set]) : rr_ptr[lookup_set];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
                plru[s] <= '0;
            end
        end else begin
            state <= state_nxt;
            idx <= busy ? idx + SET_W'(1) : '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= busy && idx == SET_W'(s) ? '0 : rr_nxt[s];
                plru[s] <= busy && idx == SET_W'(s) ? '0 : plru_nxt[s];
            end
        end
    end
endmodule

// File: tb/tb_cache_replacement_unit.sv
// tb_cache_replacement_unit: round-robin and pseudo-LRU instances checked against a prefix-indexed tree model
module tb_cache_replacement_unit;
    localparam int NS = 16;
    localparam int NW = 4;
    localparam int WW = 2;
    localparam int SW = 4;

    logic clk = 0;
    always #5 clk = ~clk;

    logic rst, access_en, replace_en, flush;
    logic [SW-1:0] lookup_set, access_set, replace_set;
    logic [NW-1:0] valid_mask;
    logic [WW-1:0] access_way, replace_way, pref_rr, pref_pl;
    logic busy_rr, busy_pl;

    cache_replacement_unit #(.NUM_SETS(NS), .NUM_WAYS(NW), .POLICY(0)) u_rr (
        .clk(clk), .rst(rst), .lookup_set(lookup_set), .valid_mask(valid_mask), .preferred(pref_rr),
        .access_en(access_en), .access_set(access_set), .access_way(access_way),
        .replace_en(replace_en), .replace_set(replace_set), .replace_way(replace_way),
        .flush(flush), .busy(busy_rr));

    cache_replacement_unit #(.NUM_SETS(NS), .NUM_WAYS(NW), .POLICY(1)) u_pl (
        .clk(clk), .rst(rst), .lookup_set(lookup_set), .valid_mask(valid_mask), .preferred(pref_pl),
        .access_en(access_en), .access_set(access_set), .access_way(access_way),
        .replace_en(replace_en), .replace_set(replace_set), .replace_way(replace_way),
        .flush(flush), .busy(busy_pl));

    int checks = 0;
    int failures = 0;
    int rr_m [NS];
    bit tree_m [NS][WW][NW/2];
    bit m_busy;
    int m_idx;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Tree bit at (level, prefix of the way index) says which half of that subrange holds the victim.
    function automatic int m_pref(int s, int pol, logic [NW-1:0] m);
        int p = 0;
        if (m_busy) return 0;
        for (int i = 0; i < NW; i++) if (!m[i]) return i;
        if (pol == 0) return rr_m[s];
        for (int l = 0; l < WW; l++) p = p * 2 + int'(tree_m[s][l][p]);
        return p;
    endfunction

    function automatic void touch(int s, int w);
        for (int l = 0; l < WW; l++) tree_m[s][l][w >> (WW - l)] = ((w >> (WW - 1 - l)) & 1) == 0;
    endfunction

    function automatic void clear_set(int s);
        rr_m[s] = 0;
        for (int l = 0; l < WW; l++)
            for (int p = 0; p < NW / 2; p++) tree_m[s][l][p] = 0;
    endfunction

    task automatic idle();
        rst = 0; flush = 0; access_en = 0; replace_en = 0; valid_mask = '1;
        access_set = 0; access_way = 0; replace_set = 0; replace_way = 0;
    endtask

    task automatic cyc();
        #1;
        check("busy_rr", busy_rr, m_busy);
        check("busy_pl", busy_pl, m_busy);
        check("pref_rr", pref_rr, m_pref(lookup_set, 0, valid_mask));
        check("pref_pl", pref_pl, m_pref(lookup_set, 1, valid_mask));
        @(posedge clk);
        if (rst) begin
            for (int s = 0; s < NS; s++) clear_set(s);
            m_busy = 0;
        end else if (m_busy) begin
            clear_set(m_idx);
            if (m_idx == NS - 1) m_busy = 0; else m_idx++;
        end else if (flush) begin
            m_busy = 1;
            m_idx = 0;
        end else begin
            if (access_en) touch(access_set, access_way);
            if (replace_en) begin
                rr_m[replace_set] = (replace_way + 1) % NW;
                touch(replace_set, replace_way);
            end
        end
        #1;
    endtask

    initial begin
        int n;
        int aw [3] = '{0, 2, 1};
        int ep [3] = '{2, 1, 3};
        idle();
        lookup_set = 0;
        rst = 1;
        @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++) clear_set(s);
        m_busy = 0;
        m_idx = 0;
        cyc();
        rst = 0;
        for (int s = 0; s < NS; s++) begin
            lookup_set = SW'(s);
            #1;
            check("rst_pref_rr", pref_rr, 0);
            check("rst_pref_pl", pref_pl, 0);
        end
        check("rst_busy", busy_rr, 0);

        lookup_set = 0;
        valid_mask = 4'b1011;
        #1;
        check("inv_rr", pref_rr, 2);
        check("inv_pl", pref_pl, 2);
        valid_mask = '1;

        lookup_set = 3;
        for (int k = 0; k < 4; k++) begin
            replace_en = 1; replace_set = 3; replace_way = WW'(k);
            cyc();
            replace_en = 0;
            #1;
            check("rr_seq", pref_rr, (k + 1) % 4);
        end
        lookup_set = 5;
        #1;
        check("rr_other_set", pref_rr, 0);

        rst = 1;
        cyc();
        rst = 0;
        lookup_set = 0;
        for (int k = 0; k < 3; k++) begin
            access_en = 1; access_set = 0; access_way = WW'(aw[k]);
            cyc();
            access_en = 0;
            #1;
            check("plru_seq", pref_pl, ep[k]);
        end

        lookup_set = 7;
        access_en = 1; access_set = 7; access_way = 0;
        replace_en = 1; replace_set = 7; replace_way = 2;
        cyc();
        idle();
        #1;
        check("same_set_pl", pref_pl, 1);
        check("same_set_rr", pref_rr, 3);

        for (int i = 0; i < 400; i++) begin
            rst = $urandom_range(99) == 0;
            flush = $urandom_range(29) == 0;
            access_en = $urandom_range(1) == 1;
            replace_en = $urandom_range(1) == 1;
            access_set = SW'($urandom_range(3));
            replace_set = SW'($urandom_range(3));
            access_way = WW'($urandom_range(NW - 1));
            replace_way = WW'($urandom_range(NW - 1));
            lookup_set = SW'($urandom_range(1) == 1 ? $urandom_range(3) : $urandom_range(NS - 1));
            valid_mask = $urandom_range(1) == 1 ? '1 : NW'($urandom_range(15));
            cyc();
        end
        idle();
        n = 0;
        while (m_busy && n < 40) begin
            cyc();
            n++;
        end

        for (int k = 0; k < 6; k++) begin
            access_en = 1; access_set = SW'(k); access_way = WW'(k % NW);
            replace_en = 1; replace_set = SW'(k + 8); replace_way = WW'((k + 1) % NW);
            cyc();
        end
        idle();
        flush = 1;
        cyc();
        flush = 0;
        n = 0;
        while (busy_rr && n < 40) begin
            replace_en = 1;
            replace_set = SW'($urandom_range(NS - 1));
            replace_way = WW'($urandom_range(NW - 1));
            lookup_set = SW'(n % NS);
            cyc();
            n++;
        end
        check("flush_len", n, NS);
        idle();
        for (int s = 0; s < NS; s++) begin
            lookup_set = SW'(s);
            #1;
            check("post_flush_rr", pref_rr, 0);
            check("post_flush_pl", pref_pl, 0);
        end

        for (int k = 0; k < 4; k++) begin
            replace_en = 1; replace_set = SW'(k); replace_way = WW'(k);
            cyc();
        end
        idle();
        flush = 1;
        cyc();
        flush = 0;
        for (int k = 0; k < 4; k++) cyc();
        rst = 1;
        cyc();
        rst = 0;
        #1;
        check("abort_busy", busy_rr, 0);
        for (int s = 0; s < NS; s++) begin
            lookup_set = SW'(s);
            #1;
            check("abort_clear_rr", pref_rr, 0);
        end
        lookup_set = 0;
        access_en = 1; access_set = 0; access_way = 0;
        cyc();
        idle();
        #1;
        check("abort_access", pref_pl, 2);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
